pcle_down: RTL and testbench
============================

# pcle_down

Loadable, cascadable down-counter with a terminal-count FSM. It is the counterpart to the loadable up-counter stage (`pcle`): it consumes a programmed count and decrements it. It produces a borrow-out for chaining and a done/irq indication on underflow.

Typical use:
- Timeout and interval timers fed by the same load/enable control bus as the up-counter.
- Wider counters built by chaining `bout` into the next stage's `bin`.

## Interface
Parameters:
- `W`, 8, counter width in bits (≥2).
- `RELOAD`, 0:
  - 0 = one-shot: stop at zero and raise `done`.
  - 1 = periodic: on underflow, reload the last loaded value.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ld`  in  1  parallel load strobe; highest priority below `rst`.
- `din`  in  W  load value.
- `en`  in  1  count enable.
- `hold`  in  1  count inhibit; overrides `en`.
- `bin`  in  1  borrow-in from less-significant stage; tie 1 for a standalone or least-significant stage.
- `q`  out  W  registered count.
- `bout`  out  1  combinational borrow-out, for cascading.
- `done`  out  1  registered; high in DONE state.
- `irq`  out  1  registered one-cycle pulse, the cycle after underflow.
- `busy`  out  1  registered; high in RUN state.

## Operation
Definitions:
- `dec = en & ~hold & ~ld & bin`.
- `uf = dec & (q == 0) & (state == RUN)`.
- `bout = uf`: purely combinational, no register in the path, so chained stages see the borrow in the same cycle.

FSM states, encoded in the package enum:
- **IDLE**: entered by reset.
  - `q` holds; `dec` is ignored.
  - `ld` → RUN.
- **RUN**:
  - `ld`: `q <= din`, `rld <= din`, stay in RUN.
  - `dec & q != 0`: `q <= q - 1`.
  - `uf & RELOAD=0`: `q` stays 0, go to DONE.
  - `uf & RELOAD=1`: `q <= rld`, stay in RUN.
- **DONE**:
  - `q` holds 0; `dec` is ignored; `bout` = 0.
  - `ld` → RUN with the new value.

General rules:
- `rld` is an internal W-bit reload register, written only by `ld`.
- Load in IDLE also writes `q` and `rld`.
- Arithmetic is modulo 2^W, but `q` never wraps to all-ones in either mode.
- Loading 0 is legal: the next `dec` causes an immediate underflow.

## Timing
Reset values:
- `q`=0, `rld`=0, state=IDLE.
- `done`=0, `irq`=0, `busy`=0.

Reset mid-operation: takes effect at the next edge, overrides `ld` and `dec`, and suppresses a pending `irq`.

Latency:
- `ld` at edge N → `q == din`, `busy` = 1 after edge N.
- Each qualifying `dec` cycle decrements `q` at that edge; the new value is visible the following cycle.
- Underflow at edge N:
  - `irq` = 1 for exactly the cycle after edge N.
  - `done` = 1 from edge N onward (one-shot mode).

Simultaneous events:
- `ld` with `dec` in the same cycle: load wins, no decrement, `bout` = 0.
- `ld` arriving in the same cycle that would have underflowed: no underflow, no `irq`.
- `hold` = 1: freezes the count regardless of `en` and `bin`; `bout` = 0.

Throughput: one decrement per cycle maximum.

## Structure
Shared package `pcle_pkg`:
- `pcle_state_e` (IDLE, RUN, DONE).
- Localparam for the default width, 8.
- It is the same package used by the up-counter stage.

Sub-module `pcle_dn_cnt`: W-bit datapath containing the `q`/`rld` registers, the decrementer and the zero detect, with the load/dec/reload selects driven by the FSM in the top level.

## Test plan
- **Reset and idle:** assert `rst` for 2 cycles, then `en`=1 for 5 cycles with no load → `q`=0, `busy`=0, `done`=0, `irq`=0, `bout`=0 throughout.
- **One-shot countdown:**
  - Stimulus: `RELOAD`=0, load `din`=3, then `en`=1, `bin`=1.
  - Response: `q` = 3,2,1,0, then `bout`=1 in the cycle `q`=0.
  - Next cycle: `irq`=1 for one cycle, `done`=1, and `q` stays 0 for 10 more cycles.
- **Periodic mode:**
  - Stimulus: `RELOAD`=1, load 2, `en` held high.
  - Response: `q` sequence 2,1,0,2,1,0,…, with an `irq` pulse every 3 cycles and `done` never asserted.
- **Hold and priority:**
  - Stimulus: load 5, count to 4, then `hold`=1 with `en`=1 for 4 cycles → `q` stays 4.
  - Then `ld`=1 with `din`=9 while `en`=1 → `q`=9, no decrement.
- **Cascade:**
  - Setup: two instances form a 16-bit counter, low stage `bin`=1, high stage `bin`=low `bout`; load 0x0100 (low=0x00, high=0x01).
  - First `dec`: low underflows (periodic low stage reloads 0x00) and high goes 1→0.
  - After 256 low-stage underflows: the high stage has underflowed.
- **Reset mid-run:** load 7, count 3 cycles, assert `rst` → next cycle `q`=0, IDLE, `busy`=0, and no `irq` pulse.

Source files
------------

// File: rtl/pcle_pkg.sv
// Shared package for the pcle counter family (up-counter and down-counter stages).
// Provides the default counter width and the terminal-count FSM state encoding.
package pcle_pkg;

    localparam int unsigned PCLE_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pcle_state_e;

endpackage

// File: rtl/pcle_down_if.sv
// Load/enable control bus and status returns for a pcle down-counter stage.
//   ld/din/en/hold/bin : control inputs driven by the master
//   q/bout/done/irq/busy : count and status returned by the counter (slave)
interface pcle_down_if
    import pcle_pkg::*;
#(
    parameter int unsigned W = PCLE_W_DEFAULT
);

    logic         ld;
    logic [W-1:0] din;
    logic         en;
    logic         hold;
    logic         bin;
    logic [W-1:0] q;
    logic         bout;
    logic         done;
    logic         irq;
    logic         busy;

    modport master (
        output ld, din, en, hold, bin,
        input  q, bout, done, irq, busy
    );

    modport slave (
        input  ld, din, en, hold, bin,
        output q, bout, done, irq, busy
    );

endinterface

// File: rtl/pcle_dn_cnt.sv
// W-bit down-counter datapath: count register, reload register, decrementer
// and zero detect. Load/dec/reload selects come from the controlling FSM.
//   clk, rst  : clock, synchronous active-high reset
//   load_i    : write din_i into both count and reload registers
//   din_i     : load value
//   dec_i     : decrement the count by one
//   reload_i  : copy the reload register into the count
//   q_o       : registered count
//   zero_o    : count is zero (combinational)
module pcle_dn_cnt
    import pcle_pkg::*;
#(
    parameter int unsigned W = PCLE_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] din_i,
    input  logic         dec_i,
    input  logic         reload_i,
    output logic [W-1:0] q_o,
    output logic         zero_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic [W-1:0] rld_q;
    logic [W-1:0] rld_d;

    // Select next count; load dominates, then reload, then decrement.
    always_comb begin
        q_d   = q_q;
        rld_d = rld_q;
        if (load_i) begin
            q_d   = din_i;
            rld_d = din_i;
        end else if (reload_i) begin
            q_d = rld_q;
        end else if (dec_i) begin
            q_d = q_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= '0;
            rld_q <= '0;
        end else begin
            q_q   <= q_d;
            rld_q <= rld_d;
        end
    end

    assign q_o    = q_q;
    assign zero_o = (q_q == '0);

endmodule

// File: rtl/pcle_down.sv
// Loadable, cascadable down-counter with terminal-count FSM.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of pcle_down_if
//              ld/din load the count, en/hold/bin qualify a decrement,
//              q is the count, bout the same-cycle borrow for the next stage,
//              done/busy reflect DONE/RUN, irq pulses the cycle after underflow.
// RELOAD=0 stops at zero in DONE; RELOAD=1 reloads the last loaded value.
module pcle_down
    import pcle_pkg::*;
#(
    parameter int unsigned W      = PCLE_W_DEFAULT,
    parameter int unsigned RELOAD = 0
) (
    input  logic        clk,
    input  logic        rst,
    pcle_down_if.slave  bus
);

    localparam bit PERIODIC = (RELOAD != 0);

    pcle_state_e state_q;
    pcle_state_e state_d;
    logic        done_q;
    logic        done_d;
    logic        irq_q;
    logic        irq_d;
    logic        busy_q;
    logic        busy_d;

    logic        dec_c;
    logic        uf_c;
    logic        q_zero_c;
    logic        cnt_dec_c;
    logic        cnt_reload_c;

    pcle_dn_cnt #(
        .W (W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load_i   (bus.ld),
        .din_i    (bus.din),
        .dec_i    (cnt_dec_c),
        .reload_i (cnt_reload_c),
        .q_o      (bus.q),
        .zero_o   (q_zero_c)
    );

    // Qualified decrement and underflow; only RUN reacts to dec.
    always_comb begin
        dec_c        = bus.en & ~bus.hold & ~bus.ld & bus.bin;
        uf_c         = dec_c & q_zero_c & (state_q == RUN);
        cnt_dec_c    = dec_c & ~q_zero_c & (state_q == RUN);
        cnt_reload_c = uf_c & PERIODIC;
    end

    // Next-state and registered status outputs.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.ld) state_d = RUN;
            end
            RUN: begin
                if (bus.ld) begin
                    state_d = RUN;
                end else if (uf_c && !PERIODIC) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.ld) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);
        busy_d = (state_d == RUN);
        irq_d  = uf_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            irq_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            irq_q   <= irq_d;
            busy_q  <= busy_d;
        end
    end

    // Borrow is unregistered so a chained stage decrements in the same cycle.
    assign bus.bout = uf_c;
    assign bus.done = done_q;
    assign bus.irq  = irq_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_pcle_down.sv
// Self-checking bench for pcle_down: one-shot and periodic instances share a
// stimulus bus and are compared every cycle against a behavioural model; a
// second pair of instances forms a 16-bit cascade.
module tb_pcle_down;
    import pcle_pkg::*;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         ld, en, hold, bin;
    logic [W-1:0] din;
    logic         c_ld, c_en;
    logic [W-1:0] c_din_lo, c_din_hi;

    pcle_down_if #(.W(W)) bus_os ();
    pcle_down_if #(.W(W)) bus_pr ();
    pcle_down_if #(.W(W)) bus_lo ();
    pcle_down_if #(.W(W)) bus_hi ();

    pcle_down #(.W(W), .RELOAD(0)) dut_os (.clk(clk), .rst(rst), .bus(bus_os));
    pcle_down #(.W(W), .RELOAD(1)) dut_pr (.clk(clk), .rst(rst), .bus(bus_pr));
    pcle_down #(.W(W), .RELOAD(1)) dut_lo (.clk(clk), .rst(rst), .bus(bus_lo));
    pcle_down #(.W(W), .RELOAD(0)) dut_hi (.clk(clk), .rst(rst), .bus(bus_hi));

    assign bus_os.ld = ld;   assign bus_os.din = din; assign bus_os.en = en;
    assign bus_os.hold = hold; assign bus_os.bin = bin;
    assign bus_pr.ld = ld;   assign bus_pr.din = din; assign bus_pr.en = en;
    assign bus_pr.hold = hold; assign bus_pr.bin = bin;

    assign bus_lo.ld = c_ld; assign bus_lo.din = c_din_lo; assign bus_lo.en = c_en;
    assign bus_lo.hold = 1'b0; assign bus_lo.bin = 1'b1;
    assign bus_hi.ld = c_ld; assign bus_hi.din = c_din_hi; assign bus_hi.en = c_en;
    assign bus_hi.hold = 1'b0; assign bus_hi.bin = bus_lo.bout;

    // Observed {q, bout, done, irq, busy}; index 0 one-shot, 1 periodic.
    logic [W+3:0] act_vec [2];
    assign act_vec[0] = {bus_os.q, bus_os.bout, bus_os.done, bus_os.irq, bus_os.busy};
    assign act_vec[1] = {bus_pr.q, bus_pr.bout, bus_pr.done, bus_pr.irq, bus_pr.busy};

    // Behavioural model: running/finished flags, integer count and reload value.
    int m_cnt [2];
    int m_rld [2];
    bit m_run [2];
    bit m_fin [2];
    bit m_irq [2];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_cnt[k] = 0; m_rld[k] = 0; m_run[k] = 0; m_fin[k] = 0; m_irq[k] = 0;
            end else if (ld) begin
                m_cnt[k] = int'(din); m_rld[k] = int'(din);
                m_run[k] = 1; m_fin[k] = 0; m_irq[k] = 0;
            end else if (m_run[k] && en && !hold && bin) begin
                if (m_cnt[k] > 0) begin
                    m_cnt[k] = m_cnt[k] - 1;
                    m_irq[k] = 0;
                end else begin
                    m_irq[k] = 1;
                    if (k == 1) begin
                        m_cnt[k] = m_rld[k];
                    end else begin
                        m_run[k] = 0;
                        m_fin[k] = 1;
                    end
                end
            end else begin
                m_irq[k] = 0;
            end
        end
    endtask

    function automatic logic [W+3:0] exp_vec(int k);
        logic bo;
        bo = m_run[k] && en && !hold && !ld && bin && (m_cnt[k] == 0);
        return {W'(m_cnt[k]), bo, m_fin[k], m_irq[k], m_run[k]};
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ld = 1'b0; en = 1'b0; hold = 1'b0; bin = 1'b1; din = '0;
        c_ld = 1'b0; c_en = 1'b0; c_din_lo = '0; c_din_hi = '0;
        repeat (2) step();
        rst = 1'b0; en = 1'b1;
        repeat (6) begin
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_vec[k] !== exp_vec(k)) begin
                    $display("FAIL reset dut%0d cyc %0d: {q,bout,done,irq,busy} got %h required %h",
                             k, cyc, act_vec[k], exp_vec(k));
                    errors++;
                end
            end
            checks++;
            if (act_vec[0] !== '0) begin
                $display("FAIL reset_idle cyc %0d: got %h required 0", cyc, act_vec[0]);
                errors++;
            end
            step();
        end
    endtask

    task automatic test_oneshot();
        int irq_seen;
        irq_seen = 0;
        ld = 1'b1; din = W'(3); en = 1'b1; bin = 1'b1; hold = 1'b0;
        for (int i = 0; i < 17; i++) begin
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_vec[k] !== exp_vec(k)) begin
                    $display("FAIL oneshot dut%0d cyc %0d: {q,bout,done,irq,busy} got %h required %h",
                             k, cyc, act_vec[k], exp_vec(k));
                    errors++;
                end
            end
            step();
            ld = 1'b0;
            if (bus_os.irq) irq_seen++;
            if (i == 0) begin
                checks++;
                if (bus_os.q !== W'(3)) begin
                    $display("FAIL oneshot_load: q got %0d required 3", bus_os.q);
                    errors++;
                end
            end
        end
        checks++;
        if (irq_seen != 1 || bus_os.done !== 1'b1 || bus_os.q !== '0) begin
            $display("FAIL oneshot_end: irqs=%0d done=%b q=%0d required irqs=1 done=1 q=0",
                     irq_seen, bus_os.done, bus_os.q);
            errors++;
        end
    endtask

    task automatic test_periodic();
        int irq_seen;
        irq_seen = 0;
        ld = 1'b1; din = W'(2); en = 1'b1; bin = 1'b1; hold = 1'b0;
        for (int i = 0; i < 13; i++) begin
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_vec[k] !== exp_vec(k)) begin
                    $display("FAIL periodic dut%0d cyc %0d: {q,bout,done,irq,busy} got %h required %h",
                             k, cyc, act_vec[k], exp_vec(k));
                    errors++;
                end
            end
            step();
            ld = 1'b0;
            if (bus_pr.irq) irq_seen++;
        end
        checks++;
        if (irq_seen != 4 || bus_pr.done !== 1'b0) begin
            $display("FAIL periodic_irqs: irqs=%0d done=%b required irqs=4 done=0",
                     irq_seen, bus_pr.done);
            errors++;
        end
    endtask

    task automatic test_hold_priority();
        ld = 1'b1; din = W'(5); en = 1'b1; bin = 1'b1; hold = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i == 1) ld = 1'b0;
            if (i == 2) hold = 1'b1;
            if (i == 6) begin
                checks++;
                if (bus_os.q !== W'(4)) begin
                    $display("FAIL hold_freeze: q got %0d required 4", bus_os.q);
                    errors++;
                end
                hold = 1'b0; ld = 1'b1; din = W'(9);
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_vec[k] !== exp_vec(k)) begin
                    $display("FAIL hold_prio dut%0d cyc %0d: {q,bout,done,irq,busy} got %h required %h",
                             k, cyc, act_vec[k], exp_vec(k));
                    errors++;
                end
            end
            step();
        end
        ld = 1'b0;
        checks++;
        if (bus_os.q !== W'(9) || bus_pr.q !== W'(9)) begin
            $display("FAIL load_wins: q got %0d/%0d required 9", bus_os.q, bus_pr.q);
            errors++;
        end
    endtask

    task automatic test_reset_mid();
        // Load 7, count 3, reset; then reset on an underflowing cycle.
        for (int i = 0; i < 9; i++) begin
            ld = (i == 0 || i == 6);
            din = (i == 0) ? W'(7) : '0;
            en = (i <= 4 || i == 6 || i == 7);
            rst = (i == 4 || i == 7);
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_vec[k] !== exp_vec(k)) begin
                    $display("FAIL reset_mid dut%0d cyc %0d: {q,bout,done,irq,busy} got %h required %h",
                             k, cyc, act_vec[k], exp_vec(k));
                    errors++;
                end
            end
            step();
            if (i == 4 || i == 7) begin
                checks++;
                if (bus_os.q !== '0 || bus_os.busy !== 1'b0 || bus_os.irq !== 1'b0 ||
                    bus_pr.irq !== 1'b0) begin
                    $display("FAIL reset_mid_state: q=%0d busy=%b irq=%b/%b required 0",
                             bus_os.q, bus_os.busy, bus_os.irq, bus_pr.irq);
                    errors++;
                end
            end
        end
        rst = 1'b0; ld = 1'b0; en = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 63) == 0);
            ld   = ($urandom_range(0, 7) == 0);
            din  = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom_range(0, 4));
            en   = ($urandom_range(0, 3) != 0);
            hold = ($urandom_range(0, 7) == 0);
            bin  = ($urandom_range(0, 3) != 0);
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_vec[k] !== exp_vec(k)) begin
                    $display("FAIL random dut%0d cyc %0d: {q,bout,done,irq,busy} got %h required %h",
                             k, cyc, act_vec[k], exp_vec(k));
                    errors++;
                end
            end
            step();
        end
        rst = 1'b0; ld = 1'b0; en = 1'b0; hold = 1'b0; bin = 1'b1;
    endtask

    task automatic test_cascade();
        int lo_uf;
        int hi_uf;
        lo_uf = 0; hi_uf = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        c_ld = 1'b1; c_din_lo = 8'h00; c_din_hi = 8'h01; c_en = 1'b1;
        step();
        c_ld = 1'b0;
        for (int i = 0; i < 300 && lo_uf < 256; i++) begin
            #1;
            if (i == 0) begin
                checks++;
                if (bus_lo.bout !== 1'b1 || bus_hi.bout !== 1'b0) begin
                    $display("FAIL cascade_first_borrow: bout lo/hi got %b/%b required 1/0",
                             bus_lo.bout, bus_hi.bout);
                    errors++;
                end
            end
            if (bus_lo.bout) lo_uf++;
            if (bus_hi.bout) hi_uf++;
            step();
            if (i == 0) begin
                checks++;
                if (bus_lo.q !== 8'h00 || bus_hi.q !== 8'h00 || bus_lo.irq !== 1'b1 ||
                    bus_hi.busy !== 1'b1 || bus_hi.done !== 1'b0) begin
                    $display("FAIL cascade_first_dec: lo=%h hi=%h irq=%b busy=%b done=%b required 00 00 1 1 0",
                             bus_lo.q, bus_hi.q, bus_lo.irq, bus_hi.busy, bus_hi.done);
                    errors++;
                end
            end
            if (i == 1) begin
                checks++;
                if (bus_hi.done !== 1'b1 || bus_hi.irq !== 1'b1) begin
                    $display("FAIL cascade_hi_uf: done=%b irq=%b required 1 1",
                             bus_hi.done, bus_hi.irq);
                    errors++;
                end
            end
        end
        checks++;
        if (lo_uf != 256 || hi_uf != 1 || bus_hi.done !== 1'b1 || bus_hi.q !== '0 ||
            bus_hi.irq !== 1'b0 || bus_lo.busy !== 1'b1) begin
            $display("FAIL cascade_end: lo_uf=%0d hi_uf=%0d done=%b q=%0d irq=%b lo_busy=%b required 256 1 1 0 0 1",
                     lo_uf, hi_uf, bus_hi.done, bus_hi.q, bus_hi.irq, bus_lo.busy);
            errors++;
        end
        c_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_hold_priority();
        test_reset_mid();
        test_random();
        test_cascade();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
